// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-bus access FSM with alignment checks and load extension; MEM_LWLR_EN enables LWL/LWR/SWL/SWR.
package mem_access_pkg;
  typedef enum logic [3:0] {
    ALU_NOP, ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW, ALU_LWL, ALU_LWR,
    ALU_SB, ALU_SH, ALU_SW, ALU_SWL, ALU_SWR
  } alu_op_t;
endpackage

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  alu_op_t             aluop_i,
  input  logic [ADDR_W-1:0]   ramaddr_i,
  input  logic [31:0]         opr2_i,
  input  logic                excp_in_i,
  input  logic                flush_i,
  output logic [31:0]         ramdata_o,
  output logic                mtor_o,
  output logic                stallreq_o,
  output logic                exc_adel_o,
  output logic                exc_ades_o,
  output logic [ADDR_W-1:0]   badvaddr_o,
  output logic                data_req_o,
  output logic                data_wr_o,
  output logic [ADDR_W-1:0]   data_addr_o,
  output logic [DATA_W/8-1:0] data_wstrb_o,
  output logic [DATA_W-1:0]   data_wdata_o,
  input  logic                data_addr_ok_i,
  input  logic                data_data_ok_i,
  input  logic [DATA_W-1:0]   data_rdata_i
);
  localparam int B = DATA_W / 8;
  localparam int LB_W = $clog2(B);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_e;
  state_e              state_q;
  alu_op_t             op_q;
  logic [LB_W-1:0]     lane_q, lane;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [B-1:0]        strb_q, strb_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, lwlr, is_ld, is_st, mis, valid, issue;
  logic [31:0]         res_q, res_d, w32, sh;
`ifdef MEM_LWLR_EN
  logic [3:0]          m4;
  logic [LB_W-1:0]     wo;
  logic [1:0]          k, kq;
  logic [31:0]         word;
`endif
  always_comb begin
    lane = ramaddr_i[LB_W-1:0];
    sh = 32'(data_rdata_i >> {lane_q, 3'b000});
    res_d = op_q == ALU_LB  ? {{24{sh[7]}}, sh[7:0]} :
            op_q == ALU_LBU ? {24'b0, sh[7:0]} :
            op_q == ALU_LH  ? {{16{sh[15]}}, sh[15:0]} :
            op_q == ALU_LHU ? {16'b0, sh[15:0]} : sh;
`ifdef MEM_LWLR_EN
    lwlr = aluop_i inside {ALU_LWL, ALU_LWR, ALU_SWL, ALU_SWR};
    k = ramaddr_i[1:0];
    wo = lane & ~LB_W'(3);
    m4 = aluop_i == ALU_SWL ? 4'hF >> (2'd3 - k) : 4'hF << k;
    w32 = aluop_i == ALU_SWL ? opr2_i >> {2'd3 - k, 3'b000} :
          aluop_i == ALU_SWR ? opr2_i << {k, 3'b000} : opr2_i;
    kq = lane_q[1:0];
    word = 32'(data_rdata_i >> {lane_q & ~LB_W'(3), 3'b000});
    if (op_q == ALU_LWL)
      res_d = (word << {2'd3 - kq, 3'b000}) | (opr2_i & ~(32'hFFFF_FFFF << {2'd3 - kq, 3'b000}));
    if (op_q == ALU_LWR)
      res_d = (word >> {kq, 3'b000}) | (opr2_i & ~(32'hFFFF_FFFF >> {kq, 3'b000}));
`else
    lwlr = 1'b0;
    w32 = opr2_i;
`endif
    is_ld = aluop_i inside {ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW} ||
            (lwlr && aluop_i inside {ALU_LWL, ALU_LWR});
    is_st = aluop_i inside {ALU_SB, ALU_SH, ALU_SW} ||
            (lwlr && aluop_i inside {ALU_SWL, ALU_SWR});
    mis = (aluop_i inside {ALU_LH, ALU_LHU, ALU_SH} && ramaddr_i[0]) ||
          (aluop_i inside {ALU_LW, ALU_SW} && ramaddr_i[1:0] != 2'b00);
    exc_adel_o = is_ld && mis;
    exc_ades_o = is_st && mis;
    badvaddr_o = mis ? ramaddr_i : '0;
    valid = (is_ld || is_st) && !mis && !excp_in_i && !flush_i;
    addr_d = lwlr ? {ramaddr_i[ADDR_W-1:2], 2'b00} : ramaddr_i;
    strb_d = aluop_i == ALU_SB ? B'(1) << lane :
             aluop_i == ALU_SH ? B'(3) << lane :
             aluop_i == ALU_SW ? B'(15) << lane : '0;
`ifdef MEM_LWLR_EN
    if (aluop_i inside {ALU_SWL, ALU_SWR}) strb_d = B'(m4) << wo;
`endif
    wdata_d = aluop_i == ALU_SB ? {B{opr2_i[7:0]}} :
              aluop_i == ALU_SH ? {(B/2){opr2_i[15:0]}} : {(B/4){w32}};
    issue = state_q == IDLE && valid;
    data_req_o = issue || state_q == REQ;
    data_wr_o = issue ? is_st : state_q == REQ && wr_q;
    data_addr_o = issue ? addr_d : state_q == REQ ? addr_q : '0;
    data_wstrb_o = issue ? strb_d : state_q == REQ ? strb_q : '0;
    data_wdata_o = issue ? wdata_d : state_q == REQ ? wdata_q : '0;
    stallreq_o = data_req_o || state_q == WAIT || (state_q == DRAIN && valid);
    mtor_o = state_q == DONE && !wr_q;
    ramdata_o = res_q;
  end
  // Fields are latched at issue so REQ keeps them stable until the bus accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= ALU_NOP;
      lane_q <= '0;
      addr_q <= '0;
      strb_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      res_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (valid) begin
          op_q <= aluop_i;
          lane_q <= lane;
          addr_q <= addr_d;
          strb_q <= strb_d;
          wdata_q <= wdata_d;
          wr_q <= is_st;
          state_q <= data_addr_ok_i ? WAIT : REQ;
        end
        REQ: if (flush_i) state_q <= data_addr_ok_i ? DRAIN : IDLE;
             else if (data_addr_ok_i) state_q <= WAIT;
        WAIT: if (data_data_ok_i) begin
          if (!wr_q && !flush_i) res_q <= res_d;
          state_q <= flush_i ? IDLE : DONE;
        end else if (flush_i) state_q <= DRAIN;
        DONE: state_q <= IDLE;
        default: if (data_data_ok_i) state_q <= IDLE;
      endcase
    end
  end
endmodule
